// File: rtl/rv32i_pkg.sv
// Shared RV32I multi-cycle control definitions: FSM states, opcode
// constants, ALU operation codes, writeback selects and control bundle.
package rv32i_pkg;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b0001;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b1101;

    localparam logic [1:0] WSEL_ALU = 2'b00;
    localparam logic [1:0] WSEL_MEM = 2'b01;
    localparam logic [1:0] WSEL_IMM = 2'b10;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_LUI     = 3'd5,
        CLS_AUIPC   = 3'd6,
        CLS_ILLEGAL = 3'd7
    } opclass_t;

    typedef struct packed {
        logic       irEn;
        logic       pcEn;
        logic       illegal;
        logic       branch;
        logic [3:0] aluCtrl;
        logic       srcA;
        logic       srcB;
        logic [1:0] regWrDataSel;
        logic       wrEn;
        logic       dataRdEn;
        logic       dataWrEn;
    } ctrl_t;

    function automatic opclass_t classify(input logic [6:0] opcode);
        opclass_t c;
        case (opcode)
            OP_R:      c = CLS_R;
            OP_I:      c = CLS_I;
            OP_LOAD:   c = CLS_LOAD;
            OP_STORE:  c = CLS_STORE;
            OP_BRANCH: c = CLS_BRANCH;
            OP_LUI:    c = CLS_LUI;
            OP_AUIPC:  c = CLS_AUIPC;
            default:   c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multi_cycle_control_inst_decode.sv
// Combinational opcode-to-control-word decoder, qualified by FSM state.
// Ports: state (FSM state), inst (latched instruction) -> ctrl, cls.
import rv32i_pkg::*;

module inst_decode (
    input  state_t      state,
    input  logic [31:0] inst,
    output ctrl_t       ctrl,
    output opclass_t    cls
);

    logic [2:0] funct3;
    logic       f7b5;
    logic       hold;
    logic [3:0] aluSel;
    logic       unusedBits;

    assign funct3     = inst[14:12];
    assign f7b5       = inst[30];
    assign unusedBits = ^{inst[31], inst[29:15], inst[11:7]};
    assign cls        = classify(inst[6:0]);

    // ALU and operand selects stay put from EXECUTE through WB
    assign hold = (state == EXECUTE) || (state == MEM) || (state == WB);

    always_comb begin
        aluSel = ALU_ADD;
        case (cls)
            CLS_R:      aluSel = {f7b5, funct3};
            CLS_I:      aluSel = (funct3 == 3'b101) ? {f7b5, funct3}
                                                    : {1'b0, funct3};
            CLS_BRANCH: aluSel = {1'b0, funct3};
            default:    aluSel = ALU_ADD;
        endcase
    end

    always_comb begin
        ctrl = '0;
        if (hold) begin
            ctrl.aluCtrl = aluSel;
            ctrl.srcA    = (cls == CLS_AUIPC);
            ctrl.srcB    = (cls == CLS_I) || (cls == CLS_LOAD) ||
                           (cls == CLS_STORE) || (cls == CLS_LUI) ||
                           (cls == CLS_AUIPC);
        end
        unique case (1'b1)
            (state == FETCH): begin
                ctrl.irEn = 1'b1;
            end
            (state == DECODE): begin
                if (cls == CLS_ILLEGAL) begin
                    ctrl.illegal = 1'b1;
                    ctrl.pcEn    = 1'b1;
                end
            end
            (state == EXECUTE): begin
                if (cls == CLS_BRANCH) begin
                    ctrl.branch = 1'b1;
                    ctrl.pcEn   = 1'b1;
                end
            end
            (state == MEM): begin
                // completion pcEn depends on iMem_Ready, added by the top
                ctrl.dataRdEn = (cls == CLS_LOAD);
                ctrl.dataWrEn = (cls == CLS_STORE);
            end
            (state == WB): begin
                ctrl.wrEn = 1'b1;
                ctrl.pcEn = 1'b1;
                case (cls)
                    CLS_LOAD: ctrl.regWrDataSel = WSEL_MEM;
                    CLS_LUI:  ctrl.regWrDataSel = WSEL_IMM;
                    default:  ctrl.regWrDataSel = WSEL_ALU;
                endcase
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// RV32I multi-cycle control FSM (FETCH/DECODE/EXECUTE/MEM/WB) with memory
// wait timeout and retired-instruction counter. Ports: iClk, iRst, iInst_Code,
// iMem_Ready in; register/ALU/memory control, oIllegal, oMem_Timeout, oInstret out.
import rv32i_pkg::*;

module multi_cycle_control #(
    parameter int DATA_WAIT_MAX = 15
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] iInst_Code,
    input  logic        iMem_Ready,
    output logic        oIR_En,
    output logic        oPC_En,
    output logic [2:0]  oFunct3,
    output logic [3:0]  oALU_Control,
    output logic [1:0]  oRegWrDataSel,
    output logic        oALUSrcMuxSel1,
    output logic        oALUSrcMuxSel2,
    output logic        oWrEn,
    output logic        oData_RdEn,
    output logic        oData_WrEn,
    output logic        oBranch,
    output logic        oIllegal,
    output logic        oMem_Timeout,
    output logic [31:0] oInstret
);

    localparam int WCW = (DATA_WAIT_MAX < 2) ? 1 : $clog2(DATA_WAIT_MAX + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(DATA_WAIT_MAX - 1);

    state_t         state;
    state_t         stateNext;
    logic [31:0]    rInst;
    logic [WCW-1:0] waitCnt;
    ctrl_t          decCtrl;
    opclass_t       cls;
    logic           inMem;
    logic           memDone;
    logic           memExpire;
    logic           pcEnRaw;
    logic           live;
    logic           retire;

    inst_decode uDecode (
        .state (state),
        .inst  (rInst),
        .ctrl  (decCtrl),
        .cls   (cls)
    );

    assign inMem     = (state == MEM);
    assign memDone   = inMem && iMem_Ready;
    // expiry fires on the last permitted low cycle; ready wins a tie
    assign memExpire = inMem && !iMem_Ready && (waitCnt == WAIT_LAST);
    assign pcEnRaw   = decCtrl.pcEn | (memDone && (cls == CLS_STORE)) |
                       memExpire;

    // a reset cycle suppresses every strobe, including an in-flight MEM access
    assign live = !iRst;

    assign oIR_En         = live && decCtrl.irEn;
    assign oPC_En         = live && pcEnRaw;
    assign oFunct3        = live ? rInst[14:12] : 3'b000;
    assign oALU_Control   = live ? decCtrl.aluCtrl : 4'b0000;
    assign oRegWrDataSel  = live ? decCtrl.regWrDataSel : 2'b00;
    assign oALUSrcMuxSel1 = live && decCtrl.srcA;
    assign oALUSrcMuxSel2 = live && decCtrl.srcB;
    assign oWrEn          = live && decCtrl.wrEn;
    assign oData_RdEn     = live && decCtrl.dataRdEn;
    assign oData_WrEn     = live && decCtrl.dataWrEn;
    assign oBranch        = live && decCtrl.branch;
    assign oIllegal       = live && decCtrl.illegal;
    assign oMem_Timeout   = live && memExpire;

    assign retire = oPC_En && !oIllegal && !oMem_Timeout;

    always_comb begin
        stateNext = state;
        case (state)
            FETCH: stateNext = DECODE;
            DECODE: begin
                stateNext = (cls == CLS_ILLEGAL) ? FETCH : EXECUTE;
            end
            EXECUTE: begin
                if ((cls == CLS_LOAD) || (cls == CLS_STORE)) begin
                    stateNext = MEM;
                end else if (cls == CLS_BRANCH) begin
                    stateNext = FETCH;
                end else begin
                    stateNext = WB;
                end
            end
            MEM: begin
                if (memDone) begin
                    stateNext = (cls == CLS_LOAD) ? WB : FETCH;
                end else if (memExpire) begin
                    stateNext = FETCH;
                end else begin
                    stateNext = MEM;
                end
            end
            WB:      stateNext = FETCH;
            default: stateNext = FETCH;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= FETCH;
            rInst    <= '0;
            waitCnt  <= '0;
            oInstret <= '0;
        end else begin
            state <= stateNext;
            if (state == FETCH) begin
                rInst <= iInst_Code;
            end
            if (inMem && !iMem_Ready && !memExpire) begin
                waitCnt <= waitCnt + WCW'(1);
            end else begin
                waitCnt <= '0;
            end
            // natural 32-bit wrap
            if (retire) begin
                oInstret <= oInstret + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized self-checking bench for multi_cycle_control against a
// per-instruction behavioural model of the control sequence.
module tb_multi_cycle_control;

    localparam int WMAX = 15;

    localparam int K_R   = 0;
    localparam int K_I   = 1;
    localparam int K_LD  = 2;
    localparam int K_ST  = 3;
    localparam int K_BR  = 4;
    localparam int K_LUI = 5;
    localparam int K_AUI = 6;
    localparam int K_ILL = 7;

    logic        iClk = 1'b0;
    logic        iRst;
    logic [31:0] iInst_Code;
    logic        iMem_Ready;
    logic        oIR_En;
    logic        oPC_En;
    logic [2:0]  oFunct3;
    logic [3:0]  oALU_Control;
    logic [1:0]  oRegWrDataSel;
    logic        oALUSrcMuxSel1;
    logic        oALUSrcMuxSel2;
    logic        oWrEn;
    logic        oData_RdEn;
    logic        oData_WrEn;
    logic        oBranch;
    logic        oIllegal;
    logic        oMem_Timeout;
    logic [31:0] oInstret;

    int          nChk = 0;
    int          nPass = 0;
    logic [31:0] mInstret;
    logic [31:0] mLast;

    multi_cycle_control #(.DATA_WAIT_MAX(WMAX)) dut (
        .iClk           (iClk),
        .iRst           (iRst),
        .iInst_Code     (iInst_Code),
        .iMem_Ready     (iMem_Ready),
        .oIR_En         (oIR_En),
        .oPC_En         (oPC_En),
        .oFunct3        (oFunct3),
        .oALU_Control   (oALU_Control),
        .oRegWrDataSel  (oRegWrDataSel),
        .oALUSrcMuxSel1 (oALUSrcMuxSel1),
        .oALUSrcMuxSel2 (oALUSrcMuxSel2),
        .oWrEn          (oWrEn),
        .oData_RdEn     (oData_RdEn),
        .oData_WrEn     (oData_WrEn),
        .oBranch        (oBranch),
        .oIllegal       (oIllegal),
        .oMem_Timeout   (oMem_Timeout),
        .oInstret       (oInstret)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nChk++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    function automatic int kindOf(input logic [6:0] op);
        int k;
        case (op)
            7'h33:   k = K_R;
            7'h13:   k = K_I;
            7'h03:   k = K_LD;
            7'h23:   k = K_ST;
            7'h63:   k = K_BR;
            7'h37:   k = K_LUI;
            7'h17:   k = K_AUI;
            default: k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic logic [31:0] actVec();
        return {13'b0, oIR_En, oPC_En, oFunct3, oALU_Control, oRegWrDataSel,
                oALUSrcMuxSel1, oALUSrcMuxSel2, oWrEn, oData_RdEn,
                oData_WrEn, oBranch, oIllegal, oMem_Timeout};
    endfunction

    // w: MEM cycles with ready low before ready rises; rstAt: MEM cycle
    // index at which reset is asserted (-1 for none)
    task automatic runInst(input string name, input logic [31:0] inst,
                           input int w, input int rstAt);
        int k;
        int ph;
        int m;
        logic [2:0] f3;
        logic ir, pc, wr, rd, wd, br, il, to, sa, sb;
        logic [3:0] alu;
        logic [1:0] ws;
        logic [31:0] exp;
        k  = kindOf(inst[6:0]);
        ph = 0;
        m  = 0;
        while (ph != 5) begin
            @(negedge iClk);
            iInst_Code = (ph == 0) ? inst : $urandom;
            iMem_Ready = (ph == 3) ? (m >= w) : 1'($urandom);
            iRst       = (ph == 3) && (m == rstAt);
            #1;
            {ir, pc, wr, rd, wd, br, il, to, sa, sb} = '0;
            alu = 4'd0;
            ws  = 2'd0;
            f3  = inst[14:12];
            if (ph >= 2) begin
                if (k == K_R) alu = {inst[30], f3};
                else if (k == K_I) alu = (f3 == 3'd5) ? {inst[30], f3} : {1'b0, f3};
                else if (k == K_BR) alu = {1'b0, f3};
                sa = (k == K_AUI);
                sb = (k == K_I) || (k == K_LD) || (k == K_ST) ||
                     (k == K_LUI) || (k == K_AUI);
            end
            if (iRst) begin
                check({name, "_rst_ctl"}, actVec(), 32'd0);
                check({name, "_rst_ret"}, oInstret, mInstret);
                mInstret = 32'd0;
                mLast    = 32'd0;
                ph       = 5;
            end else begin
                case (ph)
                    0: begin
                        ir = 1'b1;
                        f3 = mLast[14:12];
                        mLast = inst;
                        ph = 1;
                    end
                    1: begin
                        if (k == K_ILL) begin
                            il = 1'b1;
                            pc = 1'b1;
                            ph = 5;
                        end else begin
                            ph = 2;
                        end
                    end
                    2: begin
                        if (k == K_BR) begin
                            br = 1'b1;
                            pc = 1'b1;
                            ph = 5;
                        end else if (k == K_LD || k == K_ST) begin
                            ph = 3;
                        end else begin
                            ph = 4;
                        end
                    end
                    3: begin
                        rd = (k == K_LD);
                        wd = (k == K_ST);
                        if (m >= w) begin
                            if (k == K_ST) begin
                                pc = 1'b1;
                                ph = 5;
                            end else begin
                                ph = 4;
                            end
                        end else if (m == WMAX - 1) begin
                            to = 1'b1;
                            pc = 1'b1;
                            ph = 5;
                        end else begin
                            m++;
                        end
                    end
                    default: begin
                        wr = 1'b1;
                        pc = 1'b1;
                        ws = (k == K_LD) ? 2'b01 : (k == K_LUI) ? 2'b10 : 2'b00;
                        ph = 5;
                    end
                endcase
                exp = {13'b0, ir, pc, f3, alu, ws, sa, sb, wr, rd, wd, br, il, to};
                check({name, "_ctl"}, actVec(), exp);
                check({name, "_ret"}, oInstret, mInstret);
                if (pc && !il && !to) mInstret = mInstret + 32'd1;
            end
        end
    endtask

    initial begin
        logic [6:0] ops[7];
        logic [6:0] op;
        logic [31:0] inst;
        int kk;
        int w;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17};
        mInstret   = 32'd0;
        mLast      = 32'd0;
        iRst       = 1'b1;
        iInst_Code = 32'hDEADBEEF;
        iMem_Ready = 1'b1;
        repeat (2) @(negedge iClk);
        #1;
        check("reset_ctl", actVec(), 32'd0);
        check("reset_ret", oInstret, 32'd0);

        runInst("add",   32'h002081B3, 0, -1);
        runInst("sw",    32'h0020A223, 3, -1);
        runInst("lw",    32'h0040A183, 0, -1);
        runInst("beq",   32'h00208463, 0, -1);
        runInst("ill",   32'h00000000, 0, -1);
        runInst("lw_to", 32'h0040A183, WMAX, -1);
        runInst("lw_14", 32'h0040A183, WMAX - 1, -1);
        runInst("sra",   32'h4020D193, 0, -1);
        runInst("sw_rst", 32'h0020A223, 10, 1);
        runInst("add2",  32'h002081B3, 0, -1);

        for (int n = 0; n < 250; n++) begin
            kk = $urandom_range(0, 7);
            if (kk == K_ILL) begin
                op = 7'($urandom_range(0, 127));
                while (kindOf(op) != K_ILL) op = 7'($urandom_range(0, 127));
            end else begin
                op = ops[kk];
            end
            inst = {$urandom, 7'b0} | {25'b0, op};
            w = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3)
                                           : $urandom_range(12, 18);
            runInst("rnd", inst, w, -1);
        end

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter: DATA_WAIT_MAX, default 15, maximum MEM-state cycles before oMem_Timeout.
REQ-002 iClk  in  1  single clock; all state changes on its rising edge.
REQ-003 iRst  in  1  reset, synchronous and active-high.
REQ-004 iInst_Code  in  32  instruction memory read data; sampled only in FETCH.
REQ-005 iMem_Ready  in  1  data memory completion handshake for load/store.
REQ-006 oIR_En  out  1  enables the instruction register capture.
REQ-007 oPC_En  out  1  enables the PC update; pulses exactly once per instruction.
REQ-008 oFunct3  out  3  funct3 of the latched instruction.
REQ-009 oALU_Control  out  4  ALU operation code.
REQ-010 oRegWrDataSel  out  2  writeback source: 00 ALU, 01 data memory, 10 immediate (LUI).
REQ-011 oALUSrcMuxSel1 / oALUSrcMuxSel2  out  1 each  ALU operand A = PC when 1; operand B = immediate when 1.
REQ-012 oWrEn  out  1  register file write enable.
REQ-013 oData_RdEn / oData_WrEn  out  1 each  data memory read/write request.
REQ-014 oBranch  out  1  branch-evaluate qualifier for the PC-select logic.
REQ-015 oIllegal  out  1  one-cycle pulse on an unsupported opcode.
REQ-016 oMem_Timeout  out  1  one-cycle pulse when the memory wait expires.
REQ-017 oInstret  out  32  retired-instruction counter.

Function
REQ-018 FSM states SHALL be FETCH, DECODE, EXECUTE, MEM, WB.
REQ-019 FETCH: oIR_En=1; iInst_Code captured into internal rInst; next DECODE.
REQ-020 DECODE: all outputs 0 except oFunct3; illegal opcode -> oIllegal=1, oPC_En=1, next FETCH; else next EXECUTE.
REQ-021 Supported opcodes: R, I-ALU, load, store, branch, LUI, AUIPC; all others illegal.
REQ-022 EXECUTE: oALU_Control/oALUSrcMuxSel* per opcode; R = {funct7[5],funct3}; I-ALU = {funct7[5],funct3} for funct3=101, else {0,funct3}; branch = {0,funct3}; all others ADD (0000).
REQ-023 EXECUTE transitions: load/store -> MEM; branch -> oBranch=1, oPC_En=1, FETCH; all others -> WB.
REQ-024 MEM: store holds oData_WrEn=1, load holds oData_RdEn=1, until iMem_Ready=1 sampled.
REQ-025 MEM exit on iMem_Ready: store -> oPC_En=1, FETCH; load -> WB.
REQ-026 MEM wait counter counts iMem_Ready-low cycles; at DATA_WAIT_MAX -> oMem_Timeout=1, oPC_En=1, no writeback, FETCH.
REQ-027 WB: oWrEn=1, oPC_En=1, oRegWrDataSel per opcode (load 01, LUI 10, else 00); next FETCH.
REQ-028 ALU/mux selects SHALL be held stable from EXECUTE through WB of the same instruction.
REQ-029 Latency in cycles: R/I/LUI/AUIPC = 4; branch = 3; store = 4+waits; load = 5+waits; illegal = 2.
REQ-030 oInstret SHALL increment by 1 on each oPC_En, except when oIllegal or oMem_Timeout is asserted.
REQ-031 oInstret SHALL wrap 0xFFFFFFFF -> 0 silently.
REQ-032 iMem_Ready outside MEM SHALL be ignored.

Reset
REQ-033 iRst=1 SHALL force state FETCH, rInst=0, wait counter=0, oInstret=0, and all other outputs 0 on the next edge.
REQ-034 Reset during MEM SHALL drop oData_RdEn/oData_WrEn on the next cycle without oWrEn or oPC_En.
REQ-035 First FETCH SHALL occur in the first cycle after iRst deasserts.

Structure
REQ-036 Opcode constants, ALU op codes and the state enum SHALL live in shared package rv32i_pkg.
REQ-037 Opcode-to-control-word mapping SHALL be a combinational sub-module inst_decode, driven by rInst and qualified by FSM state.

Verification
REQ-038 ADD 0x002081B3: FETCH/DECODE/EXECUTE/WB; oALU_Control=0000; oWrEn for 1 cycle; oInstret 0->1.
REQ-039 SW 0x0020A223, iMem_Ready high on 4th MEM cycle: oData_WrEn high 4 cycles; oWrEn never; oFunct3=010.
REQ-040 LW 0x0040A183, immediate ready: 5 cycles; oRegWrDataSel=01 in WB; oWrEn for 1 cycle.
REQ-041 BEQ 0x00208463: 3 cycles; oBranch and oPC_En together in EXECUTE; oALU_Control=0000.
REQ-042 0x00000000 -> oIllegal pulse in DECODE, oInstret unchanged; then load with iMem_Ready low 15 cycles -> oMem_Timeout, no oWrEn.
REQ-043 iRst asserted in 2nd MEM cycle of a store: next cycle FETCH, oData_WrEn=0, oInstret=0.
